// File: rtl/kernel_stream_feeder.sv
// kernel_stream_feeder: host-loaded vn/y buffers streamed as paired words
// to the kernel input ports, with a 2-entry skid over the RAM read latency.
module kernel_stream_feeder #(
    parameter int STREAMW = 34,
    parameter int DEPTH   = 1024,
    parameter int AW      = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic               wr_sel,
    input  logic [AW-1:0]      wr_addr,
    input  logic [STREAMW-1:0] wr_data,
    input  logic               start,
    input  logic [AW:0]        nwords,
    output logic               busy,
    output logic               done,
    output logic [STREAMW-1:0] vn_s0,
    output logic [STREAMW-1:0] y_s0,
    output logic               ivalid_vn_s0,
    output logic               ivalid_y_s0,
    input  logic               iready
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRIME,
        S_STREAM,
        S_DONE
    } state_t;

    localparam logic [AW:0] DEPTH_N = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_N   = (AW+1)'(1);

    logic [STREAMW-1:0] vn_mem [DEPTH];
    logic [STREAMW-1:0] y_mem  [DEPTH];

    state_t             state_q, state_d;
    logic [AW:0]        n_q, n_d;
    logic [AW:0]        rd_ptr_q, rd_ptr_d;
    logic [AW:0]        sent_q, sent_d;
    logic               done_q, done_d;

    logic               out_v_q, out_v_d;
    logic               pf_v_q, pf_v_d;
    logic [STREAMW-1:0] out_vn_q, out_y_q;
    logic [STREAMW-1:0] pf_vn_q, pf_y_q;

    logic               running;
    logic               wr_ok;
    logic               xfer;
    logic [1:0]         occ;
    logic [1:0]         occ_after;
    logic               rd_en;
    logic [AW-1:0]      rd_addr;
    logic               shift;
    logic               ld_out;
    logic               ld_pf;
    logic [AW:0]        nw_clamp;

    assign running   = (state_q == S_PRIME) || (state_q == S_STREAM);
    assign wr_ok     = wr_en && !running && ({1'b0, wr_addr} < DEPTH_N);
    assign xfer      = out_v_q && iready;
    assign occ       = {1'b0, out_v_q} + {1'b0, pf_v_q};
    assign occ_after = occ - {1'b0, xfer};
    assign rd_en     = running && (rd_ptr_q < n_q) && (occ_after != 2'd2);
    assign rd_addr   = rd_ptr_q[AW-1:0];
    assign shift     = xfer && pf_v_q;
    assign ld_out    = rd_en && (occ_after == 2'd0);
    assign ld_pf     = rd_en && (occ_after == 2'd1);
    assign nw_clamp  = (nwords > DEPTH_N) ? DEPTH_N : nwords;

    // Host write port; buffers are left intact by reset and frozen during a run.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            if (wr_sel) begin
                y_mem[wr_addr] <= wr_data;
            end else begin
                vn_mem[wr_addr] <= wr_data;
            end
        end
    end

    // Run sequencing: start/prime/stream/done plus read and transfer counters.
    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        rd_ptr_d = rd_ptr_q;
        sent_d   = sent_q;
        done_d   = done_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    if (nwords == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d  = S_PRIME;
                        n_d      = nw_clamp;
                        rd_ptr_d = '0;
                        sent_d   = '0;
                        done_d   = 1'b0;
                    end
                end
            end
            S_PRIME: begin
                state_d  = S_STREAM;
                rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, rd_en};
            end
            S_STREAM: begin
                rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, rd_en};
                sent_d   = sent_q + {{AW{1'b0}}, xfer};
                if (xfer && (sent_q + ONE_N == n_q)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Skid occupancy: a new read lands in the first slot free after this transfer.
    always_comb begin
        out_v_d = (occ_after != 2'd0) || rd_en;
        pf_v_d  = (occ_after == 2'd2) || ((occ_after == 2'd1) && rd_en);
        if ((state_d == S_IDLE) || (state_d == S_DONE)) begin
            out_v_d = 1'b0;
            pf_v_d  = 1'b0;
        end
    end

    // Control state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            n_q      <= '0;
            rd_ptr_q <= '0;
            sent_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            rd_ptr_q <= rd_ptr_d;
            sent_q   <= sent_d;
            done_q   <= done_d;
        end
    end

    // Output and prefetch registers, loaded straight from the synchronous read.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_v_q  <= 1'b0;
            pf_v_q   <= 1'b0;
            out_vn_q <= '0;
            out_y_q  <= '0;
            pf_vn_q  <= '0;
            pf_y_q   <= '0;
        end else begin
            out_v_q <= out_v_d;
            pf_v_q  <= pf_v_d;
            if (shift) begin
                out_vn_q <= pf_vn_q;
                out_y_q  <= pf_y_q;
            end
            if (ld_out) begin
                out_vn_q <= vn_mem[rd_addr];
                out_y_q  <= y_mem[rd_addr];
            end
            if (ld_pf) begin
                pf_vn_q <= vn_mem[rd_addr];
                pf_y_q  <= y_mem[rd_addr];
            end
        end
    end

    assign busy         = running;
    assign done         = done_q;
    assign vn_s0        = out_vn_q;
    assign y_s0         = out_y_q;
    assign ivalid_vn_s0 = out_v_q;
    assign ivalid_y_s0  = out_v_q;

endmodule

// File: tb/tb_kernel_stream_feeder.sv
// tb_kernel_stream_feeder: random-iready streaming runs checked against
// shadow copies of the host buffers and the expected index sequence.
module tb_kernel_stream_feeder;

    localparam int STREAMW = 34;
    localparam int DEPTH   = 1024;
    localparam int AW      = 10;

    logic               clk = 1'b0;
    logic               rst;
    logic               wr_en;
    logic               wr_sel;
    logic [AW-1:0]      wr_addr;
    logic [STREAMW-1:0] wr_data;
    logic               start;
    logic [AW:0]        nwords;
    logic               busy;
    logic               done;
    logic [STREAMW-1:0] vn_s0;
    logic [STREAMW-1:0] y_s0;
    logic               ivalid_vn_s0;
    logic               ivalid_y_s0;
    logic               iready;

    logic [STREAMW-1:0] vn_ref [DEPTH];
    logic [STREAMW-1:0] y_ref  [DEPTH];

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    kernel_stream_feeder #(
        .STREAMW(STREAMW),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_sel      (wr_sel),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .start       (start),
        .nwords      (nwords),
        .busy        (busy),
        .done        (done),
        .vn_s0       (vn_s0),
        .y_s0        (y_s0),
        .ivalid_vn_s0(ivalid_vn_s0),
        .ivalid_y_s0 (ivalid_y_s0),
        .iready      (iready)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [STREAMW-1:0] rnd_word();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[STREAMW-1:0];
    endfunction

    function automatic bit next_ready(input int mode, input int k);
        int r;
        r = k % 6;
        case (mode)
            0:       return 1'b1;
            1:       return (r == 0) || (r == 3) || (r == 5);
            2:       return 1'($urandom_range(0, 1));
            default: return $urandom_range(0, 3) != 0;
        endcase
    endfunction

    task automatic host_write(input bit sel, input int addr,
                              input logic [STREAMW-1:0] d);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_addr = AW'(addr);
        wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic load(input int n, input bit pattern);
        logic [STREAMW-1:0] v;
        logic [STREAMW-1:0] yv;
        for (int i = 0; i < n; i++) begin
            v  = pattern ? STREAMW'(i) : rnd_word();
            yv = pattern ? STREAMW'(100 + i) : rnd_word();
            host_write(1'b0, i, v);
            host_write(1'b1, i, yv);
            vn_ref[i] = v;
            y_ref[i]  = yv;
        end
    endtask

    task automatic run(input int nw, input int mode, input bit poke);
        int                 exp_n;
        int                 idx;
        int                 cyc;
        int                 budget;
        int                 k;
        bit                 pstall;
        logic [STREAMW-1:0] pvn;
        logic [STREAMW-1:0] py;
        exp_n  = (nw > DEPTH) ? DEPTH : nw;
        nwords = (AW+1)'(nw);
        start  = 1'b1;
        iready = next_ready(mode, 0);
        k      = 1;
        @(negedge clk);
        start = 1'b0;
        check("prime_valid", ivalid_vn_s0, 0);
        check("prime_busy", busy, 1);
        check("prime_done", done, 0);
        @(negedge clk);
        check("first_valid", ivalid_vn_s0, 1);
        idx    = 0;
        cyc    = 0;
        pstall = 1'b0;
        pvn    = '0;
        py     = '0;
        budget = exp_n * 12 + 40;
        while (idx < exp_n && cyc < budget) begin
            start  = 1'b0;
            wr_en  = 1'b0;
            iready = next_ready(mode, k);
            k++;
            if (mode == 0 || pstall) begin
                check("valid_held", ivalid_vn_s0, 1);
            end
            if (ivalid_vn_s0) begin
                check("valid_y", ivalid_y_s0, 1);
                check("vn_data", vn_s0, vn_ref[idx]);
                check("y_data", y_s0, y_ref[idx]);
                if (pstall) begin
                    check("stall_vn", vn_s0, pvn);
                    check("stall_y", y_s0, py);
                end
            end else begin
                check("valid_y_low", ivalid_y_s0, 0);
            end
            if (poke && cyc == 3) begin
                start   = 1'b1;
                nwords  = (AW+1)'(5);
                wr_en   = 1'b1;
                wr_sel  = 1'b0;
                wr_addr = '0;
                wr_data = ~vn_ref[0];
            end
            pstall = ivalid_vn_s0 && !iready;
            pvn    = vn_s0;
            py     = y_s0;
            if (ivalid_vn_s0 && iready) idx++;
            @(negedge clk);
            cyc++;
        end
        start  = 1'b0;
        wr_en  = 1'b0;
        iready = 1'b0;
        if (idx < exp_n) check("timeout_xfers", idx, exp_n);
        check("end_valid", ivalid_vn_s0, 0);
        check("end_busy", busy, 0);
        check("end_done", done, 1);
        iready = 1'b1;
        @(negedge clk);
        check("post_valid", ivalid_vn_s0, 0);
        check("post_done", done, 1);
    endtask

    initial begin
        int idx;
        int cyc;
        int n;
        rst     = 1'b0;
        wr_en   = 1'b0;
        wr_sel  = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        start   = 1'b0;
        nwords  = '0;
        iready  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_vvn", ivalid_vn_s0, 0);
        check("rst_vy", ivalid_y_s0, 0);
        check("rst_vn", vn_s0, 0);
        check("rst_y", y_s0, 0);
        rst = 1'b1;
        @(negedge clk);

        start  = 1'b1;
        nwords = '0;
        iready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("zero_done", done, 1);
        check("zero_busy", busy, 0);
        check("zero_valid", ivalid_vn_s0, 0);
        @(negedge clk);
        check("zero_valid2", ivalid_vn_s0, 0);
        check("zero_valid_y", ivalid_y_s0, 0);

        load(8, 1'b1);
        run(8, 0, 1'b0);
        run(8, 1, 1'b0);
        run(8, 2, 1'b0);

        load(DEPTH, 1'b0);
        run(DEPTH + 5, 3, 1'b0);

        run(8, 2, 1'b1);
        run(8, 0, 1'b0);

        nwords = (AW+1)'(8);
        start  = 1'b1;
        iready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        idx = 0;
        cyc = 0;
        while (idx < 3 && cyc < 20) begin
            if (ivalid_vn_s0) begin
                check("abort_vn", vn_s0, vn_ref[idx]);
                idx++;
            end
            @(negedge clk);
            cyc++;
        end
        if (idx < 3) check("abort_timeout", idx, 3);
        rst    = 1'b0;
        iready = 1'b0;
        @(negedge clk);
        check("abort_valid", ivalid_vn_s0, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        rst = 1'b1;
        @(negedge clk);
        run(8, 0, 1'b0);

        for (int t = 0; t < 4; t++) begin
            n = $urandom_range(1, 40);
            load(n, 1'b0);
            run(n, $urandom_range(0, 3), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
